// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: load/store size codes and load-unit FSM states.
// No ports; imported by the load unit, its extractor and the load-unit interface users.
// Combinational definitions only.
package cpu_pkg;

    // Load size selectors carried on lscontrol; code 3 is reserved and behaves as lw.
    localparam logic [1:0] LS_LW = 2'd0;
    localparam logic [1:0] LS_LH = 2'd1;
    localparam logic [1:0] LS_LB = 2'd2;

    typedef enum logic [1:0] {
        LU_IDLE    = 2'd0,
        LU_WAIT    = 2'd1,
        LU_CAPTURE = 2'd2
    } lu_state_t;

endpackage

// File: rtl/load_unit_if.sv
// Load unit bundle: request side (start/lscontrol/sign_ext/addr -> busy/done/ls_out)
// and memory side (mem_addr/mem_rd -> mem_data).
// master = control FSM plus memory; slave = the load unit itself.
interface load_unit_if;

    logic        start;
    logic [1:0]  lscontrol;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic [31:0] ls_out;

    modport master (
        output start, lscontrol, sign_ext, addr, mem_data,
        input  mem_addr, mem_rd, busy, done, ls_out
    );

    modport slave (
        input  start, lscontrol, sign_ext, addr, mem_data,
        output mem_addr, mem_rd, busy, done, ls_out
    );

endinterface

// File: rtl/ls_extract.sv
// Load extraction: picks word/half/byte from a memory word and zero- or sign-extends it.
// Ports: data (32b word), lscontrol (size), sign_ext -> ls_out (32b result).
// Purely combinational, no state.
module ls_extract
    import cpu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  lscontrol,
    input  logic        sign_ext,
    output logic [31:0] ls_out
);

    always_comb begin
        ls_out = data;
        case (lscontrol)
            LS_LH:   ls_out = {{16{sign_ext & data[15]}}, data[15:0]};
            LS_LB:   ls_out = {{24{sign_ext & data[7]}}, data[7:0]};
            default: ls_out = data;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load path: issues one word read on start, waits MEM_LATENCY cycles, extracts and returns the value.
// Ports: clk, reset (async, active-high), lu (load_unit_if.slave: request, memory and result signals).
// Latency start->done is MEM_LATENCY+1 cycles; start is ignored while busy or in the done cycle.
module load_unit
    import cpu_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    load_unit_if.slave    lu
);

    localparam int            CW       = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    lu_state_t     state;
    lu_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;

    // Controls latched at acceptance so later input changes cannot disturb the load.
    logic [1:0]    ctl_q;
    logic          sext_q;
    logic [31:0]   addr_q;
    logic [31:0]   res_q;
    logic [31:0]   ext_dat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            LU_IDLE: begin
                if (lu.start) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = LU_WAIT;
                end
            end
            LU_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = LU_CAPTURE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            LU_CAPTURE: begin
                state_nxt = LU_IDLE;
            end
            default: begin
                state_nxt = LU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            ctl_q  <= LS_LW;
            sext_q <= 1'b0;
            addr_q <= '0;
            res_q  <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (accept) begin
                ctl_q  <= lu.lscontrol;
                sext_q <= lu.sign_ext;
                addr_q <= lu.addr;
            end
            if (state == LU_CAPTURE) begin
                res_q <= ext_dat;
            end
        end
    end

    ls_extract u_extract (
        .data      (lu.mem_data),
        .lscontrol (ctl_q),
        .sign_ext  (sext_q),
        .ls_out    (ext_dat)
    );

    // mem_data only becomes valid in the CAPTURE cycle itself, so the result is
    // forwarded combinationally then and held from res_q afterwards. Strobes are
    // state decodes, which makes reset drop them asynchronously.
    assign lu.mem_addr = addr_q;
    assign lu.mem_rd   = (state == LU_WAIT);
    assign lu.busy     = (state == LU_WAIT);
    assign lu.done     = (state == LU_CAPTURE);
    assign lu.ls_out   = (state == LU_CAPTURE) ? ext_dat : res_q;

endmodule
